// File: rtl/mprj_pad_drive_arbiter.sv
// Round-robin arbiter that hands the testbench-side mprj_io pad drivers to one stimulus
// agent at a time, with a turnaround gap between owners and an optional hold limit.
module mprj_pad_drive_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int NUM_PADS    = 38,
  parameter int TURN_CYCLES = 2,
  parameter int MAX_HOLD    = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*NUM_PADS-1:0]  req_mask,
  input  logic [NUM_REQ*NUM_PADS-1:0]  req_data,
  output logic [NUM_REQ-1:0]           grant,
  output logic [NUM_REQ-1:0]           revoked,
  output logic [NUM_PADS-1:0]          pad_out,
  output logic [NUM_PADS-1:0]          pad_oe,
  output logic                         busy
);

  localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int HOLD_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam logic [3:0]        TURN_LAST = 4'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, OWN, TURN} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     owner_q, owner_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic [3:0]           turn_cnt_q, turn_cnt_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   revoked_q, revoked_d;
  logic [NUM_PADS-1:0]  pad_out_q, pad_out_d;
  logic [NUM_PADS-1:0]  pad_oe_q, pad_oe_d;
  logic                 busy_q, busy_d;

  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic [NUM_REQ-1:0]   own_bit;
  logic [NUM_PADS-1:0]  own_mask, own_data;
  logic                 release_vol, release_forced;
  int                   idx;

  always_comb begin
    // NOTE: every signal gets a default here so no path can leave it unassigned (no latches).
    state_d        = state_q;
    owner_d        = owner_q;
    rr_ptr_d       = rr_ptr_q;
    hold_cnt_d     = hold_cnt_q;
    turn_cnt_d     = turn_cnt_q;
    grant_d        = grant_q;
    revoked_d      = '0;
    pad_out_d      = '0;
    pad_oe_d       = '0;
    found          = 1'b0;
    winner         = '0;
    idx            = 0;
    own_bit        = NUM_REQ'(1) << owner_q;
    own_mask       = req_mask[int'(owner_q)*NUM_PADS +: NUM_PADS];
    own_data       = req_data[int'(owner_q)*NUM_PADS +: NUM_PADS];
    release_vol    = ~req[owner_q];
    release_forced = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST) && ((req & ~own_bit) != '0);

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end

    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = OWN;
          owner_d    = winner;
          grant_d    = NUM_REQ'(1) << winner;
          hold_cnt_d = '0;
        end
      end
      OWN: begin
        if (release_vol || release_forced) begin
          grant_d    = '0;
          rr_ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          revoked_d  = release_vol ? '0 : own_bit;
          turn_cnt_d = '0;
          state_d    = (TURN_CYCLES > 0) ? TURN : IDLE;
        end else begin
          pad_oe_d  = own_mask;
          pad_out_d = own_data & own_mask;
          if (hold_cnt_q != HOLD_SAT) hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      TURN: begin
        grant_d = '0;
        if (turn_cnt_q == TURN_LAST) state_d = IDLE;
        else                         turn_cnt_d = turn_cnt_q + 1'b1;
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    // NOTE: state updates use <= so every flop samples pre-edge values; reset is synchronous.
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      hold_cnt_q <= '0;
      turn_cnt_q <= '0;
      grant_q    <= '0;
      revoked_q  <= '0;
      pad_out_q  <= '0;
      pad_oe_q   <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_cnt_q <= hold_cnt_d;
      turn_cnt_q <= turn_cnt_d;
      grant_q    <= grant_d;
      revoked_q  <= revoked_d;
      pad_out_q  <= pad_out_d;
      pad_oe_q   <= pad_oe_d;
      busy_q     <= busy_d;
    end
  end

  assign grant   = grant_q;
  assign revoked = revoked_q;
  assign pad_out = pad_out_q;
  assign pad_oe  = pad_oe_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_mprj_pad_drive_arbiter.sv
// Self-checking bench for mprj_pad_drive_arbiter: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a behavioural ownership model.
module tb_mprj_pad_drive_arbiter;

  localparam int NR = 4;
  localparam int NP = 38;
  localparam int TC = 2;
  localparam int MH = 64;

  logic                clock = 1'b0;
  logic                reset;
  logic [NR-1:0]       req;
  logic [NR*NP-1:0]    req_mask;
  logic [NR*NP-1:0]    req_data;
  logic [NR-1:0]       grant;
  logic [NR-1:0]       revoked;
  logic [NP-1:0]       pad_out;
  logic [NP-1:0]       pad_oe;
  logic                busy;

  mprj_pad_drive_arbiter #(
    .NUM_REQ(NR), .NUM_PADS(NP), .TURN_CYCLES(TC), .MAX_HOLD(MH)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_mask(req_mask), .req_data(req_data),
    .grant(grant), .revoked(revoked), .pad_out(pad_out), .pad_oe(pad_oe), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic set_agent(input int a, input logic [NP-1:0] m, input logic [NP-1:0] d);
    req_mask[a*NP +: NP] = m;
    req_data[a*NP +: NP] = d;
  endtask

  // Invariants: at most one owner, and pads only drive after a grant was visible.
  logic          inv_en = 1'b0;
  logic [NR-1:0] prev_grant = '0;
  always @(negedge clock) begin
    if (inv_en) begin
      check("inv_onehot0_grant", 64'($onehot0(grant)), 64'(1));
      check("inv_oe_after_grant", 64'((pad_oe == '0) || (prev_grant != '0)), 64'(1));
      prev_grant = grant;
    end
  end

  // Behavioural reference: who owns the pads, for how long, and how much gap remains.
  int            m_owner = -1;
  int            m_held  = 0;
  int            m_gap   = 0;
  int            m_ptr   = 0;
  logic [NR-1:0] e_grant, e_revoked;
  logic [NP-1:0] e_oe, e_out;
  logic          e_busy;

  task automatic model_step();
    logic others, drop, evict;
    e_revoked = '0;
    e_oe      = '0;
    e_out     = '0;
    if (reset) begin
      m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0;
    end else if (m_owner >= 0) begin
      others = (req & ~(NR'(1) << m_owner)) != '0;
      drop   = !req[m_owner];
      evict  = (MH > 0) && (m_held == MH) && others;
      if (drop || evict) begin
        if (!drop) e_revoked[m_owner] = 1'b1;
        m_ptr   = (m_owner + 1) % NR;
        m_owner = -1;
        m_gap   = TC;
      end else begin
        e_oe  = req_mask[m_owner*NP +: NP];
        e_out = req_data[m_owner*NP +: NP] & e_oe;
        if (m_held <= MH) m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < NR; k++) begin
        if (m_owner < 0 && req[(m_ptr + k) % NR]) begin
          m_owner = (m_ptr + k) % NR;
          m_held  = 1;
        end
      end
    end
    e_grant = (m_owner >= 0) ? NR'(1) << m_owner : '0;
    e_busy  = (m_owner >= 0) || (m_gap > 0);
  endtask

  typedef struct {
    logic          rst;
    logic [NR-1:0] req;
    logic [NP-1:0] mask0;
    logic [NP-1:0] data0;
    logic [NR-1:0] grant;
    logic [NP-1:0] oe;
    logic [NP-1:0] out;
    logic          busy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int gap, cnt, zeros;
    int order [5];
    logic rev_seen, oe_bad;
    logic [NP-1:0] m5;

    // Only agent 0 requests; agents 1..3 present all-ones masks that must never reach the pads.
    vecs[0]  = '{1'b1, 4'h0, 38'h0,           38'h0,           4'h0, 38'h0,           38'h0,           1'b0};
    vecs[1]  = '{1'b0, 4'h1, 38'h0FF,         38'h0A5,         4'h1, 38'h0,           38'h0,           1'b1};
    vecs[2]  = '{1'b0, 4'h1, 38'h0FF,         38'h0A5,         4'h1, 38'h0FF,         38'h0A5,         1'b1};
    vecs[3]  = '{1'b0, 4'h1, 38'h03F,         38'h015,         4'h1, 38'h03F,         38'h015,         1'b1};
    vecs[4]  = '{1'b0, 4'h1, 38'h03F,         38'h0FF,         4'h1, 38'h03F,         38'h03F,         1'b1};
    vecs[5]  = '{1'b1, 4'h1, 38'h03F,         38'h0FF,         4'h0, 38'h0,           38'h0,           1'b0};
    vecs[6]  = '{1'b0, 4'h1, 38'h03F,         38'h0FF,         4'h1, 38'h0,           38'h0,           1'b1};
    vecs[7]  = '{1'b0, 4'h0, 38'h03F,         38'h0FF,         4'h0, 38'h0,           38'h0,           1'b1};
    vecs[8]  = '{1'b0, 4'h0, 38'h03F,         38'h0FF,         4'h0, 38'h0,           38'h0,           1'b1};
    vecs[9]  = '{1'b0, 4'h0, 38'h03F,         38'h0FF,         4'h0, 38'h0,           38'h0,           1'b0};
    vecs[10] = '{1'b0, 4'h1, 38'h20_0000_0001, 38'h3F_FFFF_FFFF, 4'h1, 38'h0,           38'h0,           1'b1};
    vecs[11] = '{1'b0, 4'h1, 38'h20_0000_0001, 38'h3F_FFFF_FFFF, 4'h1, 38'h20_0000_0001, 38'h20_0000_0001, 1'b1};

    reset    = 1'b1;
    req      = '0;
    req_mask = '1;
    req_data = '1;

    for (int i = 0; i < 12; i++) begin
      reset = vecs[i].rst;
      req   = vecs[i].req;
      set_agent(0, vecs[i].mask0, vecs[i].data0);
      step();
      inv_en = 1'b1;
      check($sformatf("vec%0d_grant", i),   64'(grant),   64'(vecs[i].grant));
      check($sformatf("vec%0d_pad_oe", i),  64'(pad_oe),  64'(vecs[i].oe));
      check($sformatf("vec%0d_pad_out", i), 64'(pad_out), 64'(vecs[i].out));
      check($sformatf("vec%0d_busy", i),    64'(busy),    64'(vecs[i].busy));
      check($sformatf("vec%0d_revoked", i), 64'(revoked), 64'(0));
    end

    // Owner 0 releases while agent 2 waits; rr_ptr moves to 1, so agent 2 wins after the gap.
    do_reset();
    req = 4'b0101;
    step();
    check("t2_first_grant", 64'(grant), 64'(4'b0001));
    repeat (3) step();
    req = 4'b0100;
    step();
    check("t2_release_grant", 64'(grant), 64'(0));
    check("t2_release_oe", 64'(pad_oe), 64'(0));
    gap = 1;
    while (grant == '0 && gap < 10) begin
      step();
      if (grant == '0) begin
        gap++;
        check("t2_turn_oe", 64'(pad_oe), 64'(0));
      end
    end
    check("t2_gap_len", 64'(gap), 64'(TC + 1));
    check("t2_next_grant", 64'(grant), 64'(4'b0100));

    // All four request; each owner holds five cycles then lets go.
    do_reset();
    order = '{0, 1, 2, 3, 0};
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      zeros = (k == 0) ? 0 : 1;
      while (grant == '0 && zeros < 20) begin
        step();
        if (grant == '0) zeros++;
      end
      check($sformatf("t3_order%0d", k), 64'(grant), 64'(NR'(1) << order[k]));
      if (k > 0) check($sformatf("t3_gap%0d", k), 64'(zeros), 64'(TC + 1));
      repeat (4) step();
      req[order[k]] = 1'b0;
      step();
      check($sformatf("t3_drop%0d", k), 64'(grant), 64'(0));
      req[order[k]] = 1'b1;
    end

    // Agent 0 holds forever; agent 2 arrives at owner cycle 10 and forces a handover.
    do_reset();
    req = 4'b0001;
    step();
    check("t4_grant0", 64'(grant), 64'(4'b0001));
    cnt = 0;
    repeat (9) begin
      step();
      cnt++;
    end
    req = 4'b0101;
    while (cnt < 200) begin
      step();
      cnt++;
      if (revoked != '0) break;
    end
    check("t4_revoke_cycle", 64'(cnt), 64'(MH));
    check("t4_revoked", 64'(revoked), 64'(4'b0001));
    check("t4_grant_dropped", 64'(grant), 64'(0));
    step();
    check("t4_revoke_pulse", 64'(revoked), 64'(0));
    step();
    check("t4_still_turn", 64'(grant), 64'(0));
    step();
    check("t4_grant2", 64'(grant), 64'(4'b0100));

    // A lone requester is never revoked and its pads stay put.
    do_reset();
    m5 = 38'h15_5555_AAAA;
    set_agent(0, m5, 38'h3F_0F0F_0F0F);
    req = 4'b0001;
    step();
    step();
    rev_seen = 1'b0;
    oe_bad   = 1'b0;
    repeat (200) begin
      step();
      if (revoked != '0) rev_seen = 1'b1;
      if (pad_oe != m5 || grant != 4'b0001) oe_bad = 1'b1;
    end
    check("t5_no_revoke", 64'(rev_seen), 64'(0));
    check("t5_oe_stable", 64'(oe_bad), 64'(0));
    check("t5_pad_out", 64'(pad_out), 64'(m5 & 38'h3F_0F0F_0F0F));

    // Randomized traffic with sticky requests, occasional resets, random masks and data.
    reset = 1'b1;
    req   = '0;
    model_step();
    step();
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int a = 0; a < NR; a++) begin
        if (req[a]) req[a] = ($urandom_range(0, 63) != 0);
        else        req[a] = ($urandom_range(0, 3) == 0);
      end
      for (int b = 0; b < NR*NP; b++) begin
        req_mask[b] = 1'($urandom_range(0, 1));
        req_data[b] = 1'($urandom_range(0, 1));
      end
      model_step();
      step();
      check("rnd_grant",   64'(grant),   64'(e_grant));
      check("rnd_revoked", 64'(revoked), 64'(e_revoked));
      check("rnd_pad_oe",  64'(pad_oe),  64'(e_oe));
      check("rnd_pad_out", 64'(pad_out), 64'(e_out));
      check("rnd_busy",    64'(busy),    64'(e_busy));
    end

    inv_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
